// File: rtl/freq_gen.sv
// Programmable square-wave generator: period/high time in clk cycles,
// new settings are staged and only take effect on a period boundary.
module freq_gen #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned PER_RST  = 100000,
  parameter int unsigned HIGH_RST = 50000,
  parameter int unsigned CYC_W    = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_period,
  input  logic [CNT_W-1:0] i_high,
  output logic             o_sig,
  output logic             o_tick,
  output logic             o_pend,
  output logic [CYC_W-1:0] o_cycles
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] per_act, high_act, per_nxt, high_nxt;
  logic [CNT_W-1:0] per_d, high_d, per_cap;
  logic [CYC_W-1:0] cycles_d;
  logic             last, apply, sig_d, tick_d, pend_d;

  assign last    = (state == RUN) && (cnt == per_act - CNT_W'(1));
  assign apply   = o_pend && ((state == IDLE) || last);
  assign per_cap = (i_period < CNT_W'(2)) ? CNT_W'(2) : i_period;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (i_en) state_d = RUN;
      RUN:     if (last && !i_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-cycle values so o_sig/o_tick line up
  // with the cnt value of the cycle they appear in.
  always_comb begin
    cnt_d    = '0;
    per_d    = apply ? per_nxt  : per_act;
    high_d   = apply ? high_nxt : high_act;
    cycles_d = last ? o_cycles + CYC_W'(1) : o_cycles;
    pend_d   = i_load ? 1'b1 : (apply ? 1'b0 : o_pend);
    if (state == RUN && !last) cnt_d = cnt + CNT_W'(1);
    sig_d    = (state_d == RUN) && (cnt_d < high_d);
    tick_d   = (state_d == RUN) && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= '0;
      per_act  <= CNT_W'(PER_RST);
      high_act <= CNT_W'(HIGH_RST);
      per_nxt  <= '0;
      high_nxt <= '0;
      o_sig    <= 1'b0;
      o_tick   <= 1'b0;
      o_pend   <= 1'b0;
      o_cycles <= '0;
    end else begin
      cnt      <= cnt_d;
      per_act  <= per_d;
      high_act <= high_d;
      o_sig    <= sig_d;
      o_tick   <= tick_d;
      o_pend   <= pend_d;
      o_cycles <= cycles_d;
      if (i_load) begin
        per_nxt  <= per_cap;
        high_nxt <= i_high;
      end
    end
  end

endmodule

// File: doc/freq_gen.md
Name: freq_gen

Overview:
- Programmable square-wave generator. Produces the test signal that the frequency meter measures, giving a known source for board self-test and loop-back simulation.
- Period and high time are given in system-clock cycles and loaded through a one-cycle strobe.
- A new setting takes effect only at a period boundary, so the output never has runt pulses or glitches.
- Instantiated in top next to the meter; its output feeds the meter's input pin or the testbench loop-back.

Parameters:
- CNT_W, 32: width of period, high-time and internal counters.
- PER_RST, 100000: active period after reset (1 kHz at 100 MHz clk).
- HIGH_RST, 50000: active high time after reset.
- CYC_W, 16: width of the generated-period counter.

Ports:
- clk  input  1  system clock, 100 MHz.
- rstn  input  1  asynchronous active-low reset.
- i_en  input  1  run enable, level.
- i_load  input  1  one-cycle strobe; captures i_period and i_high.
- i_period  input  CNT_W  period in clk cycles.
- i_high  input  CNT_W  high time in clk cycles.
- o_sig  output  1  generated square wave, registered.
- o_tick  output  1  one-cycle pulse on the first cycle of every period.
- o_pend  output  1  a loaded setting is waiting for a boundary.
- o_cycles  output  CYC_W  count of completed periods; wraps.

Behaviour:
- Reset (async, rstn=0):
  - o_sig=0, o_tick=0, o_pend=0, o_cycles=0.
  - state=IDLE, cnt=0.
  - Active regs per_act=PER_RST, high_act=HIGH_RST.
  - Pending regs per_nxt=0, high_nxt=0.
- Clamp rule, applied at capture: i_period<2 is stored as 2; i_high is stored unchanged.
- Load:
  - When i_load=1, per_nxt/high_nxt capture the (clamped) inputs and o_pend=1 on the next cycle.
  - A second load while pending overwrites the pending values; last load wins.
- State machine IDLE / RUN:
  - IDLE: o_sig=0, cnt=0.
    - If o_pend=1, the pending values are copied to active and o_pend clears (one cycle).
    - If i_en=1, go to RUN with cnt=0.
  - RUN: cnt counts 0..per_act-1.
    - Output: o_sig (registered) = (cnt < high_act) for the cnt value of that cycle, so o_sig is 1 one cycle after the IDLE cycle that sampled i_en=1. cnt=0 is the first cycle of each period.
    - o_tick=1 in the cycle when cnt==0.
    - On cnt==per_act-1 (last cycle of a period), o_cycles increments (wraps at 2^CYC_W), then:
      - if o_pend=1: per_act/high_act <= per_nxt/high_nxt, o_pend clears, and the new values apply from the next cnt=0;
      - if i_en=0: go to IDLE (o_sig=0 next cycle);
      - else cnt <= 0.
- Disabling: i_en falling mid-period does not truncate the period; it ends at its boundary.
- Load and boundary in the same cycle:
  - The boundary uses the pending value registered before that cycle.
  - The new strobe becomes pending and applies at the following boundary.
- Edge duties:
  - high_act=0: o_sig constantly 0.
  - high_act>=per_act: o_sig constantly 1.
  - o_tick and o_cycles still advance normally in both cases.
- Resulting output: frequency = clk/per_act; duty = min(high_act,per_act)/per_act.
- Reset mid-operation: everything returns to reset values immediately; any pending load is discarded.
- Counter widths: cnt is CNT_W bits and compares unsigned; no overflow is possible since cnt<per_act.

Test Plan:
- Reset defaults: release reset, i_en=1 → o_sig high 50000 cycles, low 50000; o_tick every 100000 cycles; o_cycles=3 after 300001 cycles.
- Glitch-free reload: running at period 10/high 5, pulse i_load with period 4/high 1 at cnt=2 → current period completes as 5H/5L; o_pend=1 until the boundary; next periods are 1H/3L.
- Clamp and extreme duty:
  - load period 0/high 0 → period 2, o_sig constantly 0, o_tick every 2 cycles;
  - load period 6/high 9 → o_sig constantly 1, o_tick every 6 cycles.
- Load collision: period 8/high 4 with pending period 6; second i_load (period 12/high 6) on the boundary cycle → the next period uses 6, the one after uses 12; o_pend stays 1 across the boundary.
- Enable/disable: deassert i_en at cnt=3 of period 10/high 5 → o_sig finishes the period, then stays 0; o_cycles +1; re-assert → o_sig high one cycle later with cnt=0.
- Async reset: assert rstn=0 mid-high with a pending load → o_sig=0 and o_pend=0 immediately; after release the output returns to the 100000/50000 defaults.
